// File: rtl/median_win_col_gen_pkg.sv
// Shared definitions for the median filter column generator and its sort stage.
// Holds default geometry, row-fill states and the column framing flags.
package median_win_col_gen_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_LINE_WIDTH = 640;

  // How many rows of the current frame are already held in the line buffers.
  typedef enum logic [1:0] {
    ROW_FIRST  = 2'd0,
    ROW_SECOND = 2'd1,
    ROW_FULL   = 2'd2
  } row_e;

  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } frame_flags_t;

  // Row state after an end-of-line, saturating once three rows are available.
  function automatic row_e row_advance(input row_e row);
    case (row)
      ROW_FIRST: row_advance = ROW_SECOND;
      default:   row_advance = ROW_FULL;
    endcase
  endfunction

endpackage

// File: rtl/median_line_buf.sv
// One line of pixel storage: asynchronous read, synchronous write, single address.
// Maps to distributed (LUT) RAM; contents are intentionally not reset.
module median_line_buf #(
  parameter int DEPTH      = 640,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: memories get no reset branch; a reset would prevent RAM inference and the
  // top-level row masking already hides whatever the array holds after reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/median_win_col_gen.sv
// Builds one vertical 3-pixel column (rows y-2, y-1, y) per accepted raster pixel,
// using two line buffers, with a registered val/rdy output stage.
module median_win_col_gen
  import median_win_col_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
  parameter int ADDR_WIDTH = $clog2(LINE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  pix_val,
  output logic                  pix_rdy,
  input  logic                  pix_sol,
  input  logic                  pix_eol,
  input  logic                  pix_sof,
  input  logic                  pix_eof,
  output logic [DATA_WIDTH-1:0] win_pix0,
  output logic [DATA_WIDTH-1:0] win_pix1,
  output logic [DATA_WIDTH-1:0] win_pix2,
  output logic                  win_val,
  input  logic                  win_rdy,
  output logic                  win_sol,
  output logic                  win_eol,
  output logic                  win_sof,
  output logic                  win_eof
);

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(LINE_WIDTH - 1);

  logic                  acc;
  logic [ADDR_WIDTH-1:0] col_u;
  row_e                  row_u;
  logic [DATA_WIDTH-1:0] lb0_rd;
  logic [DATA_WIDTH-1:0] lb1_rd;
  logic [DATA_WIDTH-1:0] pix0_m;
  logic [DATA_WIDTH-1:0] pix1_m;

  logic [ADDR_WIDTH-1:0] col_cnt_q, col_cnt_d;
  row_e                  row_cnt_q, row_cnt_d;

  logic                  win_val_q;
  logic [DATA_WIDTH-1:0] win_pix0_q, win_pix1_q, win_pix2_q;
  frame_flags_t          win_flags_q;

  // The output stage can take a new column whenever its current one leaves or is empty.
  assign pix_rdy = win_rdy | ~win_val_q;
  assign acc     = pix_val & pix_rdy;

  // Start-of-line/frame markers override the counters so a restart is self-aligning.
  assign col_u = pix_sol ? '0 : col_cnt_q;
  assign row_u = pix_sof ? ROW_FIRST : row_cnt_q;

  // lb0 holds row y-1; on accept its old value shifts into lb1 (row y-2).
  median_line_buf #(
    .DEPTH      (LINE_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) lb0 (
    .clk       (clk),
    .wr_en_i   (acc),
    .addr_i    (col_u),
    .wr_data_i (pix_data),
    .rd_data_o (lb0_rd)
  );

  median_line_buf #(
    .DEPTH      (LINE_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) lb1 (
    .clk       (clk),
    .wr_en_i   (acc),
    .addr_i    (col_u),
    .wr_data_i (lb0_rd),
    .rd_data_o (lb1_rd)
  );

  // Rows not yet seen in this frame read as zero, hiding stale buffer contents.
  always_comb begin
    pix1_m = (row_u == ROW_FIRST) ? '0 : lb0_rd;
    pix0_m = (row_u == ROW_FULL) ? lb1_rd : '0;
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (acc) begin
      if (pix_eof) begin
        col_cnt_d = '0;
        row_cnt_d = ROW_FIRST;
      end else if (pix_eol) begin
        col_cnt_d = '0;
        row_cnt_d = row_advance(row_u);
      end else begin
        // Overlong lines keep rewriting the last buffer address.
        col_cnt_d = (col_u == LAST_COL) ? col_u : col_u + 1'b1;
        row_cnt_d = row_u;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q <= '0;
      row_cnt_q <= ROW_FIRST;
    end else begin
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_val_q <= 1'b0;
    end else if (acc) begin
      win_val_q <= 1'b1;
    end else if (win_rdy) begin
      win_val_q <= 1'b0;
    end
  end

  // Payload loads only on accept, so it stays frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_pix0_q  <= '0;
      win_pix1_q  <= '0;
      win_pix2_q  <= '0;
      win_flags_q <= '0;
    end else if (acc) begin
      win_pix0_q  <= pix0_m;
      win_pix1_q  <= pix1_m;
      win_pix2_q  <= pix_data;
      win_flags_q <= '{sol: pix_sol, eol: pix_eol, sof: pix_sof, eof: pix_eof};
    end
  end

  assign win_val  = win_val_q;
  assign win_pix0 = win_pix0_q;
  assign win_pix1 = win_pix1_q;
  assign win_pix2 = win_pix2_q;
  assign win_sol  = win_flags_q.sol;
  assign win_eol  = win_flags_q.eol;
  assign win_sof  = win_flags_q.sof;
  assign win_eof  = win_flags_q.eof;

endmodule

// File: tb/tb_median_win_col_gen.sv
// Self-checking bench for median_win_col_gen: table-driven pixel records with expected
// columns, fed through a scoreboard queue and compared as columns leave the block.
module tb_median_win_col_gen;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int AW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic          sol, eol, sof, eof;
    logic [DW-1:0] e0, e1, e2;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] pix_data;
  logic          pix_val, pix_rdy, pix_sol, pix_eol, pix_sof, pix_eof;
  logic [DW-1:0] win_pix0, win_pix1, win_pix2;
  logic          win_val, win_rdy, win_sol, win_eol, win_sof, win_eof;

  int   checks   = 0;
  int   failures = 0;
  vec_t sb[$];
  vec_t tbl[$];

  logic       rdy_mode = 1'b0;
  logic [3:0] rdy_pat  = 4'b1001;
  int         rdy_idx  = 0;
  logic       stalled  = 1'b0;
  logic [63:0] held;

  median_win_col_gen #(
    .DATA_WIDTH (DW),
    .LINE_WIDTH (LW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_data (pix_data),
    .pix_val  (pix_val),
    .pix_rdy  (pix_rdy),
    .pix_sol  (pix_sol),
    .pix_eol  (pix_eol),
    .pix_sof  (pix_sof),
    .pix_eof  (pix_eof),
    .win_pix0 (win_pix0),
    .win_pix1 (win_pix1),
    .win_pix2 (win_pix2),
    .win_val  (win_val),
    .win_rdy  (win_rdy),
    .win_sol  (win_sol),
    .win_eol  (win_eol),
    .win_sof  (win_sof),
    .win_eof  (win_eof)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int data, input logic sol, eol, sof, eof,
                              input int e0, e1, e2);
    vec_t v;
    v.data = DW'(data);
    v.sol = sol; v.eol = eol; v.sof = sof; v.eof = eof;
    v.e0 = DW'(e0); v.e1 = DW'(e1); v.e2 = DW'(e2);
    return v;
  endfunction

  // 3x4 frame of pixels base..base+11; the pixel above sits 4 values lower.
  function automatic void add_frame(input int base);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        int p;
        p = base + r * 4 + c;
        tbl.push_back(mk(p, c == 0, c == 3, r == 0 && c == 0, r == 2 && c == 3,
                         (r >= 2) ? p - 8 : 0, (r >= 1) ? p - 4 : 0, p));
      end
    end
  endfunction

  function automatic logic [63:0] col_of(input vec_t v);
    return 64'({v.e0, v.e1, v.e2, v.sol, v.eol, v.sof, v.eof});
  endfunction

  function automatic logic [63:0] dut_col();
    return 64'({win_pix0, win_pix1, win_pix2, win_sol, win_eol, win_sof, win_eof});
  endfunction

  task automatic send(input vec_t v);
    pix_data = v.data;
    pix_sol  = v.sol;
    pix_eol  = v.eol;
    pix_sof  = v.sof;
    pix_eof  = v.eof;
    pix_val  = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (pix_rdy) begin
        sb.push_back(v);
        break;
      end
      if (t == 99) check("send_timeout", 64'(pix_rdy), 64'(1));
    end
    @(posedge clk);
    #1;
    pix_val = 1'b0;
  endtask

  task automatic send_tbl(input int n);
    for (int i = 0; i < n && i < tbl.size(); i++) send(tbl[i]);
    tbl.delete();
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && (sb.size() != 0 || win_val); t++) @(negedge clk);
    check("drain_left", 64'(sb.size()), 64'(0));
    check("drain_val", 64'(win_val), 64'(0));
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode) begin
      win_rdy = rdy_pat[rdy_idx];
      rdy_idx = (rdy_idx + 1) % 4;
    end
  end

  // Monitor: compares each column as it is handed over; checks hold behaviour on stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else if (win_val && !win_rdy) begin
      check("stall_pix_rdy", 64'(pix_rdy), 64'(0));
      if (stalled) check("stall_hold", dut_col(), held);
      held    = dut_col();
      stalled = 1'b1;
    end else begin
      stalled = 1'b0;
      if (win_val) begin
        if (sb.size() == 0) begin
          check("unexpected_column", 64'(win_val), 64'(0));
        end else begin
          vec_t e;
          e = sb.pop_front();
          check("column", dut_col(), col_of(e));
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    pix_val  = 1'b0;
    pix_data = '0;
    pix_sol  = 1'b0;
    pix_eol  = 1'b0;
    pix_sof  = 1'b0;
    pix_eof  = 1'b0;
    win_rdy  = 1'b1;

    #12;
    check("rst_win_val", 64'(win_val), 64'(0));
    check("rst_pix_rdy", 64'(pix_rdy), 64'(1));
    check("rst_column", dut_col(), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic 3x4 frame at full throughput.
    add_frame(1);
    send_tbl(12);
    drain();

    // Same frame with the consumer stalling in a 1,0,0,1 pattern.
    rdy_idx  = 0;
    rdy_mode = 1'b1;
    add_frame(1);
    send_tbl(12);
    drain();
    rdy_mode = 1'b0;
    win_rdy  = 1'b1;

    // Back-to-back frames; frame 2 row 0 must not show frame 1 data.
    add_frame(1);
    add_frame(100);
    send_tbl(24);
    drain();

    // Reset in the middle of row 1.
    add_frame(1);
    send_tbl(6);
    check("pre_rst_val", 64'(win_val), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_val", 64'(win_val), 64'(0));
    check("mid_rst_pix_rdy", 64'(pix_rdy), 64'(1));
    check("mid_rst_column", dut_col(), 64'(0));
    sb.delete();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // First line after reset carries no sol/sof: reset counters alone must mask it.
    tbl.push_back(mk(200, 0, 0, 0, 0, 0, 0, 200));
    tbl.push_back(mk(201, 0, 0, 0, 0, 0, 0, 201));
    tbl.push_back(mk(202, 0, 0, 0, 0, 0, 0, 202));
    tbl.push_back(mk(203, 0, 1, 0, 1, 0, 0, 203));
    send_tbl(4);
    add_frame(150);
    send_tbl(12);
    drain();

    // Overlong line: addresses 0,1,2,3,3,3, so column 3 of the next line sees 15.
    tbl.push_back(mk(10, 1, 0, 1, 0, 0, 0, 10));
    tbl.push_back(mk(11, 0, 0, 0, 0, 0, 0, 11));
    tbl.push_back(mk(12, 0, 0, 0, 0, 0, 0, 12));
    tbl.push_back(mk(13, 0, 0, 0, 0, 0, 0, 13));
    tbl.push_back(mk(14, 0, 0, 0, 0, 0, 0, 14));
    tbl.push_back(mk(15, 0, 1, 0, 0, 0, 0, 15));
    tbl.push_back(mk(20, 1, 0, 0, 0, 0, 10, 20));
    tbl.push_back(mk(21, 0, 0, 0, 0, 0, 11, 21));
    tbl.push_back(mk(22, 0, 0, 0, 0, 0, 12, 22));
    tbl.push_back(mk(23, 0, 1, 0, 1, 0, 15, 23));
    send_tbl(10);
    drain();

    // Single-pixel line as row 1, single-pixel row 2, then a single-pixel frame.
    tbl.push_back(mk(50, 1, 0, 1, 0, 0, 0, 50));
    tbl.push_back(mk(51, 0, 1, 0, 0, 0, 0, 51));
    tbl.push_back(mk(60, 1, 1, 0, 0, 0, 50, 60));
    tbl.push_back(mk(70, 1, 1, 0, 1, 50, 60, 70));
    tbl.push_back(mk(90, 1, 1, 1, 1, 0, 0, 90));
    tbl.push_back(mk(91, 1, 0, 0, 0, 0, 0, 91));
    tbl.push_back(mk(92, 0, 1, 0, 1, 0, 0, 92));
    send_tbl(7);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
